// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared CPU definitions for the hazard controller: controller state
// encoding, forward-select codes and the load-use hazard predicate.
package pipeline_hazard_ctrl_pkg;

  // Hazard controller states, 2-bit encoding.
  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_STALL  = 2'b01,
    IMM_FETCH = 2'b10,
    HALT      = 2'b11
  } hz_state_e;

  // Operand forward-select codes used by the datapath forwarding muxes.
  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_EX   = 2'b01,
    FWD_MEM  = 2'b10,
    FWD_WB   = 2'b11
  } fwd_sel_e;

  localparam int unsigned STALL_CNT_W = 8;

  // A load in EX whose destination feeds an operand read by the decode instruction.
  function automatic logic load_use_hit(
    input logic       ex_mem_read,
    input logic [1:0] ex_addr,
    input logic       uses_rs,
    input logic [1:0] rs_addr,
    input logic       uses_rt,
    input logic [1:0] rt_addr
  );
    logic rs_hit;
    logic rt_hit;
    rs_hit = uses_rs & (ex_addr == rs_addr);
    rt_hit = uses_rt & (ex_addr == rt_addr);
    return ex_mem_read & (rs_hit | rt_hit);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter8.sv
// 8-bit up-counter that holds at 8'hFF instead of wrapping.
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_r;

  // Count register: clear on reset, step on inc until saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= 8'h00;
    end else if (inc && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'h01;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, two-byte immediate fetch,
// taken-branch squash and HLT/Resume, plus a saturating bubble counter.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ID_Rs_Addr,
  input  logic [1:0] ID_Rt_Addr,
  input  logic       ID_Uses_Rs,
  input  logic       ID_Uses_Rt,
  input  logic       ID_Is_2Byte,
  input  logic       ID_Halt,
  input  logic       EX_MemRead,
  input  logic [1:0] EX_Addr,
  input  logic       EX_Branch_Taken,
  input  logic       Resume,
  output logic       PC_Write,
  output logic       IF_ID_Write,
  output logic       IF_ID_Flush,
  output logic       ID_EX_Bubble,
  output logic       Imm_Capture,
  output logic       no_forward_one,
  output logic       no_forward_two,
  output logic       Halted,
  output logic [7:0] Stall_Count
);

  hz_state_e state_r;
  hz_state_e next_state_s;
  logic      lu_hit_s;
  logic      pc_write_s;
  logic      if_id_write_s;
  logic      if_id_flush_s;
  logic      id_ex_bubble_s;
  logic      imm_capture_s;
  logic      cnt_inc_s;
  logic      halted_r;

  assign lu_hit_s = load_use_hit(EX_MemRead, EX_Addr, ID_Uses_Rs, ID_Rs_Addr,
                                 ID_Uses_Rt, ID_Rt_Addr);

  // State and Halted flag; Halted tracks the state being entered so it is
  // already high in the first HALT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= RUN;
      halted_r <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      halted_r <= (next_state_s == HALT);
    end
  end

  // Next-state and Mealy pipeline controls; reset forces a full squash.
  always_comb begin
    next_state_s   = state_r;
    pc_write_s     = 1'b1;
    if_id_write_s  = 1'b1;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    imm_capture_s  = 1'b0;
    if (rst) begin
      next_state_s   = RUN;
      pc_write_s     = 1'b0;
      if_id_write_s  = 1'b0;
      if_id_flush_s  = 1'b1;
      id_ex_bubble_s = 1'b1;
    end else begin
      case (state_r)
        RUN: begin
          if (EX_Branch_Taken) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            next_state_s   = RUN;
          end else if (lu_hit_s) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
            next_state_s   = LU_STALL;
          end else if (ID_Halt) begin
            pc_write_s     = 1'b0;
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
            next_state_s   = HALT;
          end else if (ID_Is_2Byte) begin
            if_id_write_s  = 1'b0;
            id_ex_bubble_s = 1'b1;
            next_state_s   = IMM_FETCH;
          end else begin
            next_state_s   = RUN;
          end
        end
        LU_STALL: begin
          // The stalled consumer now sees the load result; no re-check.
          next_state_s = RUN;
        end
        IMM_FETCH: begin
          next_state_s = RUN;
          if (EX_Branch_Taken) begin
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
          end else begin
            imm_capture_s  = 1'b1;
          end
        end
        HALT: begin
          pc_write_s     = 1'b0;
          if_id_write_s  = 1'b0;
          id_ex_bubble_s = 1'b1;
          if (Resume) begin
            next_state_s = RUN;
          end else begin
            next_state_s = HALT;
          end
        end
        default: begin
          next_state_s   = RUN;
          pc_write_s     = 1'b0;
          if_id_write_s  = 1'b0;
          if_id_flush_s  = 1'b1;
          id_ex_bubble_s = 1'b1;
        end
      endcase
    end
  end

  // Bubbles injected while halted are not counted as stall cycles.
  assign cnt_inc_s = id_ex_bubble_s & (state_r != HALT);

  sat_counter8 u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (cnt_inc_s),
    .count (Stall_Count)
  );

  assign PC_Write       = pc_write_s;
  assign IF_ID_Write    = if_id_write_s;
  assign IF_ID_Flush    = if_id_flush_s;
  assign ID_EX_Bubble   = id_ex_bubble_s;
  assign Imm_Capture    = imm_capture_s;
  assign no_forward_one = ~ID_Uses_Rs;
  assign no_forward_two = ~ID_Uses_Rt;
  assign Halted         = halted_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: stimulus pushes expected
// outputs from a behavioural model, a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic [1:0] rs;
    logic [1:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       two;
    logic       halt;
    logic       mrd;
    logic [1:0] exa;
    logic       br;
    logic       res;
    logic       rst;
  } stim_t;

  typedef struct packed {
    logic       pc;
    logic       ifid;
    logic       flush;
    logic       bub;
    logic       imm;
    logic       nf1;
    logic       nf2;
    logic       halted;
    logic [7:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ID_Rs_Addr, ID_Rt_Addr, EX_Addr;
  logic       ID_Uses_Rs, ID_Uses_Rt, ID_Is_2Byte, ID_Halt;
  logic       EX_MemRead, EX_Branch_Taken, Resume;
  logic       PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, Imm_Capture;
  logic       no_forward_one, no_forward_two, Halted;
  logic [7:0] Stall_Count;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  bit   stim_done = 1'b0;

  // Reference model: what the pipeline is currently doing, as plain flags.
  bit m_halted, m_in_stall, m_in_imm;
  int m_cnt;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .ID_Rs_Addr(ID_Rs_Addr), .ID_Rt_Addr(ID_Rt_Addr),
    .ID_Uses_Rs(ID_Uses_Rs), .ID_Uses_Rt(ID_Uses_Rt),
    .ID_Is_2Byte(ID_Is_2Byte), .ID_Halt(ID_Halt),
    .EX_MemRead(EX_MemRead), .EX_Addr(EX_Addr),
    .EX_Branch_Taken(EX_Branch_Taken), .Resume(Resume),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .Imm_Capture(Imm_Capture),
    .no_forward_one(no_forward_one), .no_forward_two(no_forward_two),
    .Halted(Halted), .Stall_Count(Stall_Count)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Apply one cycle of inputs, predict outputs, advance the model, wait an edge.
  task automatic drive(input stim_t s);
    exp_t e;
    bit   lu;
    rst = s.rst; ID_Rs_Addr = s.rs; ID_Rt_Addr = s.rt;
    ID_Uses_Rs = s.use_rs; ID_Uses_Rt = s.use_rt; ID_Is_2Byte = s.two;
    ID_Halt = s.halt; EX_MemRead = s.mrd; EX_Addr = s.exa;
    EX_Branch_Taken = s.br; Resume = s.res;
    lu = s.mrd && ((s.use_rs && s.exa == s.rs) || (s.use_rt && s.exa == s.rt));
    e.nf1 = !s.use_rs;
    e.nf2 = !s.use_rt;
    e.halted = m_halted;
    e.cnt = 8'(m_cnt);
    // default: normal flow
    {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b11000;
    if (s.rst) begin
      {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b00110;
      m_halted = 1'b0; m_in_stall = 1'b0; m_in_imm = 1'b0; m_cnt = 0;
    end else if (m_halted) begin
      {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b00010;
      m_halted = !s.res;
    end else begin
      if (m_in_stall) begin
        m_in_stall = 1'b0;
      end else if (m_in_imm) begin
        m_in_imm = 1'b0;
        if (s.br) {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b11110;
        else      {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b11001;
      end else if (s.br) begin
        {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b11110;
      end else if (lu) begin
        {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b00010;
        m_in_stall = 1'b1;
      end else if (s.halt) begin
        {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b00010;
        m_halted = 1'b1;
      end else if (s.two) begin
        {e.pc, e.ifid, e.flush, e.bub, e.imm} = 5'b10010;
        m_in_imm = 1'b1;
      end
      if (e.bub && m_cnt < 255) m_cnt++;
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s.rs = 2'($urandom_range(3)); s.rt = 2'($urandom_range(3));
    s.exa = 2'($urandom_range(3));
    s.use_rs = 1'($urandom_range(1)); s.use_rt = 1'($urandom_range(1));
    s.two  = ($urandom_range(99) < 20);
    s.halt = ($urandom_range(99) < 4);
    s.mrd  = ($urandom_range(99) < 35);
    s.br   = ($urandom_range(99) < 12);
    s.res  = ($urandom_range(99) < 30);
    s.rst  = ($urandom_range(99) < 2);
    return s;
  endfunction

  // Monitor: every cycle the DUT presents outputs; compare against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("PC_Write", {7'd0, PC_Write}, {7'd0, e.pc});
        chk("IF_ID_Write", {7'd0, IF_ID_Write}, {7'd0, e.ifid});
        chk("IF_ID_Flush", {7'd0, IF_ID_Flush}, {7'd0, e.flush});
        chk("ID_EX_Bubble", {7'd0, ID_EX_Bubble}, {7'd0, e.bub});
        chk("Imm_Capture", {7'd0, Imm_Capture}, {7'd0, e.imm});
        chk("no_forward_one", {7'd0, no_forward_one}, {7'd0, e.nf1});
        chk("no_forward_two", {7'd0, no_forward_two}, {7'd0, e.nf2});
        chk("Halted", {7'd0, Halted}, {7'd0, e.halted});
        chk("Stall_Count", Stall_Count, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int    wait_cycles;
    rst = 1'b1;
    {ID_Rs_Addr, ID_Rt_Addr, EX_Addr} = 6'd0;
    {ID_Uses_Rs, ID_Uses_Rt, ID_Is_2Byte, ID_Halt} = 4'd0;
    {EX_MemRead, EX_Branch_Taken, Resume} = 3'd0;
    m_halted = 1'b0; m_in_stall = 1'b0; m_in_imm = 1'b0; m_cnt = 0;
    @(posedge clk);
    #1;
    // reset state
    s = idle(); s.rst = 1'b1;
    drive(s); drive(s);
    drive(idle());
    // load-use: LD R1 then ADD R2,R1
    s = idle(); s.mrd = 1'b1; s.exa = 2'd1; s.rt = 2'd1; s.use_rt = 1'b1; s.rs = 2'd2;
    drive(s); drive(s); drive(idle());
    // two-byte instruction
    s = idle(); s.two = 1'b1;
    drive(s); drive(idle()); drive(idle());
    // two-byte followed by a taken branch during the immediate fetch
    drive(s);
    s = idle(); s.br = 1'b1;
    drive(s); drive(idle());
    // branch wins over simultaneous load-use
    s = idle(); s.br = 1'b1; s.mrd = 1'b1; s.exa = 2'd3; s.rs = 2'd3; s.use_rs = 1'b1;
    drive(s); drive(idle());
    // halt for 10 cycles, then resume
    s = idle(); s.halt = 1'b1;
    drive(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.mrd = 1'b1; s.use_rs = 1'b1; s.br = 1'(i % 2);
      drive(s);
    end
    s = idle(); s.res = 1'b1;
    drive(s); drive(idle()); drive(idle());
    // 300 load-use events saturate the counter
    s = idle(); s.mrd = 1'b1; s.exa = 2'd2; s.rs = 2'd2; s.use_rs = 1'b1;
    for (int i = 0; i < 600; i++) drive(s);
    drive(idle()); drive(idle());
    // reset while in IMM_FETCH
    s = idle(); s.two = 1'b1;
    drive(s);
    s = idle(); s.rst = 1'b1;
    drive(s);
    drive(idle()); drive(idle());
    // randomized traffic
    for (int i = 0; i < 2000; i++) drive(rnd());
    drive(idle());
    stim_done = 1'b1;
    wait_cycles = 0;
    while (sb_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (sb_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have ports ID_Rs_Addr and ID_Rt_Addr, input, 2 bits each: source registers of the instruction in decode.
REQ-004 SHALL have ports ID_Uses_Rs and ID_Uses_Rt, input, 1 bit each: decode instruction actually reads Rs / Rt.
REQ-005 SHALL have port ID_Is_2Byte, input, 1 bit: decode instruction carries an immediate second byte.
REQ-006 SHALL have port ID_Halt, input, 1 bit: decode instruction is HLT.
REQ-007 SHALL have port EX_MemRead, input, 1 bit: EX instruction is a load.
REQ-008 SHALL have port EX_Addr, input, 2 bits: EX destination register.
REQ-009 SHALL have port EX_Branch_Taken, input, 1 bit: branch resolved taken in EX.
REQ-010 SHALL have port Resume, input, 1 bit: leave halt.
REQ-011 SHALL have ports PC_Write, IF_ID_Write, IF_ID_Flush and ID_EX_Bubble, output, 1 bit each: pipeline enables and squashes.
REQ-012 SHALL have port Imm_Capture, output, 1 bit: latch the fetched byte as the immediate.
REQ-013 SHALL have ports no_forward_one and no_forward_two, output, 1 bit each: suppress forwarding on operand A / B.
REQ-014 SHALL have port Halted, output, 1 bit, registered: core is halted.
REQ-015 SHALL have port Stall_Count, output, 8 bits, registered: bubble cycle counter.

Function
REQ-016 SHALL implement a 4-state FSM: RUN, LU_STALL, IMM_FETCH, HALT.
REQ-017 Load-use hazard (LU) SHALL be EX_MemRead && ((ID_Uses_Rs && EX_Addr==ID_Rs_Addr) || (ID_Uses_Rt && EX_Addr==ID_Rt_Addr)).
REQ-018 Priority in RUN SHALL be EX_Branch_Taken > LU > ID_Halt > ID_Is_2Byte.
REQ-019 RUN + EX_Branch_Taken: PC_Write=1, IF_ID_Flush=1, ID_EX_Bubble=1; next state RUN; pending LU, halt and 2-byte events are discarded.
REQ-020 RUN + LU: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next state LU_STALL.
REQ-021 LU_STALL: PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0; next state RUN; the LU check is not re-evaluated in this state.
REQ-022 RUN + ID_Is_2Byte: PC_Write=1, IF_ID_Write=0, ID_EX_Bubble=1; next state IMM_FETCH.
REQ-023 IMM_FETCH: Imm_Capture=1, PC_Write=1, IF_ID_Write=1, ID_EX_Bubble=0; next state RUN; EX_Branch_Taken here acts as in REQ-019 and sets Imm_Capture=0.
REQ-024 RUN + ID_Halt: PC_Write=0, IF_ID_Write=0, ID_EX_Bubble=1; next state HALT.
REQ-025 HALT: outputs as in REQ-024; Halted=1 from the first HALT cycle; Resume=1 leads to RUN next cycle with Halted=0.
REQ-026 RUN with no event: PC_Write=1, IF_ID_Write=1, and all flush, bubble and capture outputs 0.
REQ-027 no_forward_one SHALL equal !ID_Uses_Rs, and no_forward_two SHALL equal !ID_Uses_Rt; both are combinational and independent of state.
REQ-028 Stall_Count SHALL increment on each clock edge at which ID_EX_Bubble=1 and state!=HALT, saturating at 8'hFF.
REQ-029 All outputs except Halted and Stall_Count SHALL be combinational from state and inputs (Mealy).

Reset
REQ-030 With rst=1 at a clock edge: state=RUN, Halted=0, Stall_Count=8'h00, overriding any in-flight LU_STALL, IMM_FETCH or HALT.
REQ-031 While rst=1, outputs SHALL be PC_Write=0, IF_ID_Write=0, IF_ID_Flush=1, ID_EX_Bubble=1, Imm_Capture=0.

Structure
REQ-032 State encoding (2 bits) and forward-select codes SHALL live in the shared CPU package.
REQ-033 The saturating counter SHALL be one sub-module, sat_counter8.

Verification
REQ-034 LD R1 then ADD R2,R1 (EX_Addr=1, ID_Rt_Addr=1, EX_MemRead=1) -> 1 cycle PC_Write=0 / ID_EX_Bubble=1, then LU_STALL, Stall_Count=1.
REQ-035 ID_Is_2Byte=1 -> IMM_FETCH next cycle with Imm_Capture=1 for exactly 1 cycle, Stall_Count=1.
REQ-036 EX_Branch_Taken=1 with LU true in the same cycle -> IF_ID_Flush=1, state stays RUN, no LU_STALL.
REQ-037 ID_Halt=1 -> Halted=1 and Stall_Count frozen for 10 cycles; Resume=1 -> RUN and PC_Write=1 next cycle.
REQ-038 300 consecutive LU events -> Stall_Count=8'hFF, no wrap; rst=1 in IMM_FETCH -> state RUN, count 0.
